// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port of the MEM stage.
// The stage is the master; the data memory (or its model) is the slave.
interface mem_stage_if;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [3:0]  memByteEn;
  logic [31:0] memRData;
  logic        memAck;

  modport master (
    output memReq, memWe, memAddr, memWData, memByteEn,
    input  memRData, memAck
  );

  modport slave (
    input  memReq, memWe, memAddr, memWData, memByteEn,
    output memRData, memAck
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: word/byte loads and stores over a req/ack port.
// Stalls upstream while an access is outstanding and aborts on timeout.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inValid,
  input  logic        flush,
  input  logic [31:0] inResult,
  input  logic [31:0] inReadData2,
  input  logic [4:0]  inRd,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  input  logic        inWord,
  input  logic        inRegWrite,
  input  logic        inMemToReg,
  mem_stage_if.master dmem,
  output logic        stall,
  output logic        outValid,
  output logic        outRegWrite,
  output logic [4:0]  outRd,
  output logic [31:0] outWbData,
  output logic        outMisaligned,
  output logic        outBusError
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  state_t      r_state;
  logic [7:0]  r_cnt;

  // Captured instruction while the access is outstanding
  logic        r_word;
  logic        r_store;
  logic        r_reg_write;
  logic        r_mem_to_reg;
  logic [1:0]  r_lane;
  logic [4:0]  r_rd;
  logic [31:0] r_result;

  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;

  logic        r_out_valid;
  logic        r_out_reg_write;
  logic [4:0]  r_out_rd;
  logic [31:0] r_out_wb_data;
  logic        r_out_misaligned;
  logic        r_out_bus_error;

  logic        w_live;
  logic        w_mem_op;
  logic        w_misaligned;
  logic        w_issue;
  logic        w_timeout;
  logic [7:0]  w_lane_byte;
  logic [31:0] w_load_data;
  logic [31:0] w_wb_data;

  assign w_live       = inValid & ~flush;
  assign w_mem_op     = inMemRead | inMemWrite;
  assign w_misaligned = inWord & (inResult[1:0] != 2'b00);
  assign w_issue      = w_live & w_mem_op & ~w_misaligned;
  assign w_timeout    = (r_cnt == LP_TIMEOUT);

  // memAck reaches stall combinationally so EX/MEM advances on the completing edge
  assign stall = ((r_state == IDLE) & w_issue) |
                 ((r_state == BUSY) & ~dmem.memAck & (r_cnt < LP_TIMEOUT));

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_lane_byte = dmem.memRData[7:0];
    case (r_lane)
      2'd1:    w_lane_byte = dmem.memRData[15:8];
      2'd2:    w_lane_byte = dmem.memRData[23:16];
      2'd3:    w_lane_byte = dmem.memRData[31:24];
      default: w_lane_byte = dmem.memRData[7:0];
    endcase
    w_load_data = r_word ? dmem.memRData : {{24{w_lane_byte[7]}}, w_lane_byte};
    w_wb_data   = r_mem_to_reg ? w_load_data : r_result;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_cnt            <= 8'd0;
      r_word           <= 1'b0;
      r_store          <= 1'b0;
      r_reg_write      <= 1'b0;
      r_mem_to_reg     <= 1'b0;
      r_lane           <= 2'd0;
      r_rd             <= 5'd0;
      r_result         <= 32'd0;
      r_req            <= 1'b0;
      r_we             <= 1'b0;
      r_addr           <= 32'd0;
      r_wdata          <= 32'd0;
      r_be             <= 4'd0;
      r_out_valid      <= 1'b0;
      r_out_reg_write  <= 1'b0;
      r_out_rd         <= 5'd0;
      r_out_wb_data    <= 32'd0;
      r_out_misaligned <= 1'b0;
      r_out_bus_error  <= 1'b0;
    end else begin
      r_out_valid      <= 1'b0;
      r_out_reg_write  <= 1'b0;
      r_out_misaligned <= 1'b0;
      r_out_bus_error  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_live && !w_mem_op) begin
            r_out_valid     <= 1'b1;
            r_out_reg_write <= inRegWrite;
            r_out_rd        <= inRd;
            r_out_wb_data   <= inResult;
          end else if (w_live && w_misaligned) begin
            r_out_valid      <= 1'b1;
            r_out_rd         <= inRd;
            r_out_misaligned <= 1'b1;
          end else if (w_issue) begin
            r_state      <= BUSY;
            r_cnt        <= 8'd0;
            r_word       <= inWord;
            r_store      <= inMemWrite & ~inMemRead;
            r_reg_write  <= inRegWrite;
            r_mem_to_reg <= inMemToReg;
            r_lane       <= inResult[1:0];
            r_rd         <= inRd;
            r_result     <= inResult;
            r_req        <= 1'b1;
            r_we         <= inMemWrite & ~inMemRead;
            r_addr       <= {inResult[31:2], 2'b00};
            r_wdata      <= inWord ? inReadData2 : {4{inReadData2[7:0]}};
            r_be         <= inWord ? 4'b1111 : (4'b0001 << inResult[1:0]);
          end
        end
        BUSY: begin
          if (dmem.memAck) begin
            r_state         <= IDLE;
            r_req           <= 1'b0;
            r_out_valid     <= 1'b1;
            r_out_reg_write <= r_reg_write & ~r_store;
            r_out_rd        <= r_rd;
            r_out_wb_data   <= w_wb_data;
          end else if (w_timeout) begin
            r_state         <= IDLE;
            r_req           <= 1'b0;
            r_out_valid     <= 1'b1;
            r_out_rd        <= r_rd;
            r_out_bus_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dmem.memReq    = r_req;
  assign dmem.memWe     = r_we;
  assign dmem.memAddr   = r_addr;
  assign dmem.memWData  = r_wdata;
  assign dmem.memByteEn = r_be;

  assign outValid      = r_out_valid;
  assign outRegWrite   = r_out_reg_write;
  assign outRd         = r_out_rd;
  assign outWbData     = r_out_wb_data;
  assign outMisaligned = r_out_misaligned;
  assign outBusError   = r_out_bus_error;

endmodule
